// File: rtl/shift_capture_fifo_pkg.sv
// Shared definitions for the shift register and its change-capture buffer.
//   SHIFT_WIDTH : default width of the shift register value
//   sel_e       : shift register operation select encoding (also used by benches)
//   ptr_w()     : pointer width for a power-of-two entry count
package shift_pkg;

  localparam int SHIFT_WIDTH = 8;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_LOAD = 2'd1,
    SEL_SHR  = 2'd2,
    SEL_ROR  = 2'd3
  } sel_e;

  // Keep at least one pointer bit so a degenerate depth still elaborates.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/shift_capture_fifo_if.sv
// Valid/ready readout stream of the capture buffer.
//   out_valid : buffer non-empty, out_data valid
//   out_data  : oldest captured value
//   out_ready : consumer accepts out_data this cycle
// master = buffer side, slave = consumer side.
interface shift_capture_fifo_if #(
  parameter int WIDTH = shift_pkg::SHIFT_WIDTH
) ();
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/shift_capture_fifo_core.sv
// sync_fifo_core: storage, wrap-around pointers and occupancy level.
//   clk, rst     : clock, async active-low reset (clears storage too)
//   push, wdata  : write request; accepted when not full, or when full
//                  together with a pop of the head
//   pop          : read request; ignored when empty
//   rdata        : storage entry at the read pointer (no bypass)
//   full, empty  : derived from level, not from pointer equality
//   level        : occupancy 0..DEPTH
module sync_fifo_core
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW   = ptr_w(DEPTH);
  localparam int LVLW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LVLW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // Full + pop: the write lands in the slot being vacated by the head.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  // Power-of-two depth: natural pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVLW'(1);
        2'b01:   level <= level - LVLW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/shift_capture_fifo.sv
// shift_capture_fifo: captures every change of the shift register output
// into a small FIFO drained over a valid/ready stream.
//   clk, rst  : clock, async active-low reset
//   en        : capture enable
//   reg_in    : shift register parallel output
//   clr_ovf   : sync clear of overflow/drop_cnt (a same-cycle drop wins)
//   rd        : readout stream (out_valid/out_data/out_ready)
//   level     : FIFO occupancy 0..DEPTH
//   overflow  : sticky, set when a change is dropped
//   drop_cnt  : saturating count of dropped changes
module shift_capture_fifo
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIDTH-1:0]        reg_in,
  input  logic                    clr_ovf,
  shift_capture_fifo_if.master    rd,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [CNTW-1:0]         drop_cnt
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("shift_capture_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] prev;
  logic             push_req, pop, drop;
  logic             full, empty;

  // prev follows reg_in even while disabled, so enabling capture never
  // compares against a stale value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= '0;
    else      prev <= reg_in;
  end

  assign push_req     = en & (reg_in != prev);
  assign rd.out_valid = ~empty;
  assign pop          = rd.out_valid & rd.out_ready;
  assign drop         = push_req & full & ~pop;

  sync_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (reg_in),
    .pop   (pop),
    .rdata (rd.out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)        drop_cnt <= CNTW'(1);
      else if (~&drop_cnt) drop_cnt <= drop_cnt + CNTW'(1);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_shift_capture_fifo.sv
// Directed bench for shift_capture_fifo. Stimulus queues each value it
// expects to be captured; a negedge monitor pops and compares on every
// accepted handshake. Status outputs are checked inline.
module tb_shift_capture_fifo;
  import shift_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int C = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] reg_in;
  logic         clr_ovf;
  logic [$clog2(D):0] level;
  logic         overflow;
  logic [C-1:0] drop_cnt;

  shift_capture_fifo_if #(.WIDTH(W)) rd ();

  shift_capture_fifo #(.WIDTH(W), .DEPTH(D), .CNTW(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .reg_in   (reg_in),
    .clr_ovf  (clr_ovf),
    .rd       (rd.master),
    .level    (level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [W-1:0] v, input bit expect_push);
    reg_in = v;
    if (expect_push) exp_q.push_back(v);
    tick();
  endtask

  // Monitor: every accepted handshake must deliver the next queued value.
  always @(negedge clk) begin
    if (rst && rd.out_valid && rd.out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no data at %0t", rd.out_data, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rd.out_data !== e) begin
          n_fail++;
          $display("FAIL pop_data: got 0x%0h expected 0x%0h at %0t", rd.out_data, e, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b1; reg_in = '0; clr_ovf = 1'b0; rd.out_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_valid", 32'(rd.out_valid), 0);
    chk("rst_data",  32'(rd.out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf",   32'(overflow), 0);
    chk("rst_drop",  32'(drop_cnt), 0);
    tick();
    rst = 1'b1;

    // Constant input with en=1: nothing captured.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_valid", 32'(rd.out_valid), 0);
      chk("idle_level", 32'(level), 0);
    end

    // Three changes buffered, then drained back-to-back.
    cap(8'hFF, 1); cap(8'h7F, 1); cap(8'h3F, 1);
    chk("seq_level3", 32'(level), 3);
    chk("seq_head",   32'(rd.out_data), 32'hFF);
    rd.out_ready = 1'b1;
    repeat (3) tick();
    chk("seq_empty_valid", 32'(rd.out_valid), 0);
    chk("seq_empty_level", 32'(level), 0);
    rd.out_ready = 1'b0;

    // Changes while disabled are ignored; enabling with a held value too.
    en = 1'b0;
    cap(8'h11, 0); cap(8'h22, 0); cap(8'h33, 0); cap(8'h44, 0);
    chk("dis_level", 32'(level), 0);
    en = 1'b1;
    tick(); tick();
    chk("en_hold_level", 32'(level), 0);
    cap(8'h55, 1);
    chk("en_change_level", 32'(level), 1);
    rd.out_ready = 1'b1;
    tick();
    rd.out_ready = 1'b0;
    chk("en_drain_level", 32'(level), 0);

    // Fill, then overflow by three.
    cap(8'hA1, 1); cap(8'hA2, 1); cap(8'hA3, 1); cap(8'hA4, 1);
    chk("fill_level", 32'(level), 4);
    cap(8'hA5, 0); cap(8'hA6, 0); cap(8'hA7, 0);
    chk("ovf_flag",  32'(overflow), 1);
    chk("ovf_cnt",   32'(drop_cnt), 3);
    chk("ovf_level", 32'(level), 4);
    chk("ovf_head",  32'(rd.out_data), 32'hA1);
    // Clear colliding with a drop: drop wins.
    clr_ovf = 1'b1;
    cap(8'hA8, 0);
    clr_ovf = 1'b0;
    chk("clr_drop_flag", 32'(overflow), 1);
    chk("clr_drop_cnt",  32'(drop_cnt), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_flag", 32'(overflow), 0);
    chk("clr_cnt",  32'(drop_cnt), 0);

    // Drop counter saturation.
    for (int i = 0; i < 260; i++) cap((i % 2) ? 8'hE1 : 8'hE0, 0);
    chk("sat_cnt",  32'(drop_cnt), 255);
    chk("sat_flag", 32'(overflow), 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("sat_clr_cnt", 32'(drop_cnt), 0);

    // Full with a simultaneous pop: accepted, no drop, lands last.
    rd.out_ready = 1'b1;
    cap(8'hB0, 1);
    rd.out_ready = 1'b0;
    chk("fullpop_level", 32'(level), 4);
    chk("fullpop_ovf",   32'(overflow), 0);
    chk("fullpop_cnt",   32'(drop_cnt), 0);
    chk("fullpop_head",  32'(rd.out_data), 32'hA2);
    rd.out_ready = 1'b1;
    repeat (4) tick();
    rd.out_ready = 1'b0;
    chk("fullpop_drain", 32'(level), 0);

    // Asynchronous reset mid-stream.
    cap(8'hC1, 1); cap(8'hC2, 1);
    chk("mid_level2", 32'(level), 2);
    #2;
    rst = 1'b0;
    reg_in = 8'h00;
    #1;
    exp_q.delete();
    chk("arst_valid", 32'(rd.out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_data",  32'(rd.out_data), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_level", 32'(level), 0);
    cap(8'hD1, 1);
    chk("post_rst_cap", 32'(level), 1);
    rd.out_ready = 1'b1;
    tick();
    rd.out_ready = 1'b0;
    chk("post_rst_drain", 32'(level), 0);

    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
